// File: rtl/move_rx_framer.sv
// move_rx_framer: oversampling UART-style receiver for the move link between
// boards. It synchronises rx, finds the start bit, takes a 2-of-3 vote per
// bit and reports each byte with a one-cycle ready pulse. A bad stop bit
// produces a one-cycle frame_err pulse, and the line must then idle high
// before the next frame is accepted.
module move_rx_framer #(
    parameter int CLK_PER_SAMP = 423,
    parameter int SAMP_PER_BIT = 16,
    parameter int PKT_LEN      = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rx,
    output logic [PKT_LEN-1:0] data_out,
    output logic               ready,
    output logic               frame_err,
    output logic               busy
);

    // Counter widths; guarded so that a parameter of 1 still gets a 1-bit counter
    localparam int TW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
    localparam int SW = (SAMP_PER_BIT > 1) ? $clog2(SAMP_PER_BIT) : 1;
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    localparam logic [TW-1:0] TICK_MAX    = TW'(CLK_PER_SAMP - 1);
    localparam logic [SW-1:0] SAMP_MAX    = SW'(SAMP_PER_BIT - 1);
    localparam logic [SW-1:0] SAMP_FIRST  = SW'(7);
    localparam logic [SW-1:0] SAMP_SECOND = SW'(8);
    localparam logic [SW-1:0] SAMP_DECIDE = SW'(9);
    localparam logic [BW-1:0] BIT_MAX     = BW'(PKT_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t state;

    logic               sync_a;
    logic               sync_b;
    logic               rx_prev;
    logic [TW-1:0]      tick_cnt;
    logic [SW-1:0]      samp_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [SW-1:0]      high_cnt;
    logic               samp7;
    logic               samp8;
    logic [PKT_LEN-1:0] shift_reg;

    logic tick;
    logic fall;
    logic vote;
    logic decide;

    // Tick fires on the last cycle of each oversample period; the vote uses the
    // two stored samples plus the live sample-9 value so the decision is made
    // on the sample-9 tick itself.
    assign tick   = (tick_cnt == TICK_MAX);
    assign fall   = rx_prev & ~sync_b;
    assign vote   = (samp7 & samp8) | (samp7 & sync_b) | (samp8 & sync_b);
    assign decide = tick && (samp_cnt == SAMP_DECIDE);

    // Two-flop synchroniser plus edge-detect history, all resetting to the idle-high line level
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_a  <= rx;
            sync_b  <= sync_a;
            rx_prev <= sync_b;
        end
    end

    // Oversample timebase: held at zero while idle so it restarts aligned to each falling edge
    always_ff @(posedge clk_in) begin
        if (!rst_in || state == IDLE) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            if (samp_cnt == SAMP_MAX) begin
                samp_cnt <= '0;
            end else begin
                samp_cnt <= samp_cnt + 1'b1;
            end
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Capture samples 7 and 8 of the current bit for the majority vote
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            samp7 <= 1'b0;
            samp8 <= 1'b0;
        end else if (tick) begin
            if (samp_cnt == SAMP_FIRST) begin
                samp7 <= sync_b;
            end
            if (samp_cnt == SAMP_SECOND) begin
                samp8 <= sync_b;
            end
        end
    end

    // Frame state machine with registered ready/frame_err pulses and busy flag
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            high_cnt  <= '0;
            shift_reg <= '0;
            data_out  <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ready     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (fall) begin
                        state   <= START;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (decide) begin
                        if (vote) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                end

                DATA: begin
                    if (decide) begin
                        shift_reg <= {vote, shift_reg[PKT_LEN-1:1]};
                        if (bit_cnt == BIT_MAX) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (decide) begin
                        if (vote) begin
                            data_out <= shift_reg;
                            ready    <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            high_cnt  <= '0;
                            state     <= BREAK;
                        end
                    end
                end

                BREAK: begin
                    if (tick) begin
                        if (sync_b) begin
                            if (high_cnt == SAMP_MAX) begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                high_cnt <= '0;
                            end else begin
                                high_cnt <= high_cnt + 1'b1;
                            end
                        end else begin
                            high_cnt <= '0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_rx_framer.sv
// tb_move_rx_framer: directed, table-driven bench for move_rx_framer using a
// shortened oversample period so whole frames fit in a short run.
module tb_move_rx_framer;

    localparam int CPS     = 4;
    localparam int SPB     = 16;
    localparam int PLEN    = 8;
    localparam int BIT_CYC = CPS * SPB;
    // Cycles from the synchronised fall to the result pulse, plus two
    // synchroniser cycles because the bench times from the raw rx fall.
    localparam int LAT     = ((PLEN + 1) * SPB + 10) * CPS + 1;
    localparam int LAT_RAW = LAT + 2;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic            rx     = 1'b1;
    logic [PLEN-1:0] data_out;
    logic            ready;
    logic            frame_err;
    logic            busy;

    move_rx_framer #(
        .CLK_PER_SAMP(CPS),
        .SAMP_PER_BIT(SPB),
        .PKT_LEN     (PLEN)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rx       (rx),
        .data_out (data_out),
        .ready    (ready),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int       ready_cnt      = 0;
    int       ferr_cnt       = 0;
    int       both_cnt       = 0;
    int       last_ready_cyc = 0;
    int       last_ferr_cyc  = 0;
    int       fall_cyc       = 0;
    logic [7:0] last_rdy_data = 8'h00;
    logic [7:0] prev_rdy_data = 8'h00;

    // Pulse monitor, sampled on the falling clock edge
    always @(negedge clk_in) begin
        if (ready) begin
            ready_cnt++;
            last_ready_cyc = cyc;
            prev_rdy_data  = last_rdy_data;
            last_rdy_data  = data_out;
        end
        if (frame_err) begin
            ferr_cnt++;
            last_ferr_cyc = cyc;
        end
        if (ready && frame_err) both_cnt++;
    end

    int passed = 0;
    int total  = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Holds rx at v for n clocks; always called and returns at posedge+1
    task automatic driveFor(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Sends one frame; optional sample-8 glitch on each data bit, or a
    // one-cycle reset in the middle of data bit abort_bit (then returns)
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                 input logic glitch, input int abort_bit);
        fall_cyc = cyc;
        driveFor(1'b0, BIT_CYC);
        for (int i = 0; i < PLEN; i++) begin
            if (abort_bit == i) begin
                driveFor(data[i], BIT_CYC / 2);
                rst_in = 1'b0;
                @(posedge clk_in);
                #1;
                rst_in = 1'b1;
                rx     = 1'b1;
                return;
            end
            if (glitch) begin
                driveFor(data[i], 8 * CPS + CPS / 2);
                driveFor(~data[i], CPS);
                driveFor(data[i], BIT_CYC - 9 * CPS - CPS / 2);
            end else begin
                driveFor(data[i], BIT_CYC);
            end
        end
        driveFor(stop_val, BIT_CYC);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_val;
        logic       glitch;
        int         exp_ready;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int r0;
        int f0;
        int c0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 8'hA5};
        vecs[1] = '{8'h11, 1'b1, 1'b0, 1, 0, 8'h11};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 0, 1, 8'h11};
        vecs[3] = '{8'h96, 1'b1, 1'b1, 1, 0, 8'h96};
        vecs[4] = '{8'hC3, 1'b1, 1'b0, 1, 0, 8'hC3};

        // Reset state
        rst_in = 1'b0;
        rx     = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        checkOutput("reset_data_out", int'(data_out), 0);
        checkOutput("reset_ready", int'(ready), 0);
        checkOutput("reset_frame_err", int'(frame_err), 0);
        checkOutput("reset_busy", int'(busy), 0);
        rst_in = 1'b1;
        driveFor(1'b1, 8);
        checkOutput("no_false_start", int'(busy), 0);

        // Table of frames
        for (int i = 0; i < 5; i++) begin
            r0 = ready_cnt;
            f0 = ferr_cnt;
            applyStimulus(vecs[i].data, vecs[i].stop_val, vecs[i].glitch, -1);
            if (vecs[i].exp_ready == 1) begin
                checkOutput($sformatf("latency_ready_%0d", i), last_ready_cyc - fall_cyc, LAT_RAW);
            end else begin
                checkOutput($sformatf("latency_ferr_%0d", i), last_ferr_cyc - fall_cyc, LAT_RAW);
            end
            if (vecs[i].stop_val == 1'b0) begin
                driveFor(1'b0, 2 * BIT_CYC);
                checkOutput($sformatf("break_busy_low_%0d", i), int'(busy), 1);
                driveFor(1'b1, 8 * CPS);
                checkOutput($sformatf("break_busy_mid_%0d", i), int'(busy), 1);
                driveFor(1'b1, 12 * CPS);
                checkOutput($sformatf("break_busy_end_%0d", i), int'(busy), 0);
            end else begin
                driveFor(1'b1, 4 * CPS);
            end
            checkOutput($sformatf("ready_count_%0d", i), ready_cnt - r0, vecs[i].exp_ready);
            checkOutput($sformatf("ferr_count_%0d", i), ferr_cnt - f0, vecs[i].exp_ferr);
            checkOutput($sformatf("data_out_%0d", i), int'(data_out), int'(vecs[i].exp_data));
        end

        // Short start-bit glitch of three ticks
        r0 = ready_cnt;
        f0 = ferr_cnt;
        c0 = cyc;
        driveFor(1'b0, 3 * CPS);
        checkOutput("glitch_busy_early", int'(busy), 1);
        driveFor(1'b1, 30);
        checkOutput("glitch_busy_before_decide", int'(busy), 1);
        driveFor(1'b1, 1);
        checkOutput("glitch_busy_after_decide", int'(busy), 0);
        checkOutput("glitch_cycle_position", cyc - c0, 10 * CPS + 3);
        driveFor(1'b1, 2 * BIT_CYC);
        checkOutput("glitch_no_ready", ready_cnt - r0, 0);
        checkOutput("glitch_no_ferr", ferr_cnt - f0, 0);

        // Back-to-back frames with no idle gap
        r0 = ready_cnt;
        applyStimulus(8'h00, 1'b1, 1'b0, -1);
        applyStimulus(8'hFF, 1'b1, 1'b0, -1);
        driveFor(1'b1, 4 * CPS);
        checkOutput("b2b_ready_count", ready_cnt - r0, 2);
        checkOutput("b2b_first_data", int'(prev_rdy_data), 8'h00);
        checkOutput("b2b_second_data", int'(last_rdy_data), 8'hFF);

        // Reset in the middle of data bit 3, then a clean frame
        r0 = ready_cnt;
        f0 = ferr_cnt;
        applyStimulus(8'h5A, 1'b1, 1'b0, 3);
        checkOutput("midreset_data_out", int'(data_out), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_ready", int'(ready), 0);
        checkOutput("midreset_frame_err", int'(frame_err), 0);
        driveFor(1'b1, 2 * BIT_CYC);
        checkOutput("midreset_no_ready", ready_cnt - r0, 0);
        checkOutput("midreset_no_ferr", ferr_cnt - f0, 0);
        applyStimulus(8'h5A, 1'b1, 1'b0, -1);
        driveFor(1'b1, 4 * CPS);
        checkOutput("resume_ready_count", ready_cnt - r0, 1);
        checkOutput("resume_data_out", int'(data_out), 8'h5A);

        checkOutput("ready_ferr_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
